// File: rtl/rr_gnt_mux.sv
// rr_gnt_mux: grant-driven payload mux with packet lock and 2-entry output FIFO.
//
// Sits downstream of a 4-requester round-robin arbiter. The arbiter's one-hot grant
// selects one requester's beat. An accepted beat is acked in the same cycle and
// pushed into a 2-deep FIFO. Once a packet starts (an accepted beat with last=0),
// ownership is locked to that requester until its last beat. Ownership is also
// released if MAX_BURST beats arrive without a last beat; that case raises burst_err.
//
// Handshake: a beat from requester i is transferred in the cycle where ack[i]=1.
// The bench/arbiter side has no ready signal; ack is the only acceptance indication.
// On the output side, a head beat moves when out_valid && out_ready at the rising edge.
// While out_valid && !out_ready, out_data, out_src and out_last hold stable.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   gnt[3:0]           one-hot grant; 0 = idle
//   req_data           4 payloads, requester i at [i*DATA_W +: DATA_W]
//   req_last[3:0]      per-requester last-beat flag
//   ack[3:0]           combinational per-requester accept
//   out_valid/out_data/out_src/out_last/out_ready   FIFO head, valid/ready
//   lock_act, lock_src packet lock state and owner
//   err_clr            clears sticky errors
//   gnt_err            sticky: gnt had two or more bits set
//   burst_err          sticky: MAX_BURST beats without last
//   stat_beats[15:0]   saturating count of accepted beats (only with RR_GNT_MUX_STATS_EN)
//
// Optional feature macro: RR_GNT_MUX_STATS_EN (adds stat_beats).

module rr_gnt_mux #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            gnt,
    input  logic [4*DATA_W-1:0]   req_data,
    input  logic [3:0]            req_last,
    output logic [3:0]            ack,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  lock_act,
    output logic [1:0]            lock_src,
    input  logic                  err_clr,
    output logic                  gnt_err,
    output logic                  burst_err
`ifdef RR_GNT_MUX_STATS_EN
    ,
    output logic [15:0]           stat_beats
`endif
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Beat count value at which the next non-last beat hits MAX_BURST.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    lock_state_t        state;
    logic [3:0]         beats;

    logic               one_hot;
    logic               multi;
    logic [1:0]         idx;
    logic               space;
    logic               owner_ok;
    logic               accept;
    logic               pop;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic               burst_hit;

    logic [1:0]         count;
    logic               rd_ptr;
    logic               wr_ptr;
    logic [DATA_W-1:0]  mem_data [2];
    logic [1:0]         mem_src  [2];
    logic               mem_last [2];

    // Grant decode and acceptance.
    always_comb begin
        one_hot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
        multi   = (gnt != 4'd0) && !one_hot;
        case (gnt)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        sel_data = req_data[int'(idx)*DATA_W +: DATA_W];
        sel_last = req_last[idx];
        // Space uses the registered count only; a same-cycle pop does not free a slot.
        space    = (count < 2'd2);
        owner_ok = (state == UNLOCKED) || (idx == lock_src);
        accept   = one_hot && space && owner_ok;
        ack      = accept ? gnt : 4'd0;
        pop      = out_valid && out_ready;
        burst_hit = (state == LOCKED) && accept && !sel_last && (beats == BURST_LAST);
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_src   = mem_src[rd_ptr];
    assign out_last  = mem_last[rd_ptr];
    assign lock_act  = (state == LOCKED);

    // Output FIFO. Storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_src[0]  <= 2'd0;
            mem_src[1]  <= 2'd0;
            mem_last[0] <= 1'b0;
            mem_last[1] <= 1'b0;
        end else begin
            if (accept) begin
                mem_data[wr_ptr] <= sel_data;
                mem_src[wr_ptr]  <= idx;
                mem_last[wr_ptr] <= sel_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, accept} - {1'b0, pop};
        end
    end

    // Packet lock FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= UNLOCKED;
            lock_src <= 2'd0;
            beats    <= 4'd0;
        end else begin
            case (state)
                UNLOCKED: begin
                    // A last=1 beat while unlocked is a single-beat packet.
                    if (accept && !sel_last) begin
                        state    <= LOCKED;
                        lock_src <= idx;
                        beats    <= 4'd1;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (sel_last || burst_hit) begin
                            state <= UNLOCKED;
                            beats <= 4'd0;
                        end else begin
                            beats <= beats + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= UNLOCKED;
                    beats <= 4'd0;
                end
            endcase
        end
    end

    // Sticky errors: a new error in the clear cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_err   <= 1'b0;
            burst_err <= 1'b0;
        end else begin
            gnt_err   <= multi     | (gnt_err   & ~err_clr);
            burst_err <= burst_hit | (burst_err & ~err_clr);
        end
    end

`ifdef RR_GNT_MUX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats <= 16'd0;
        end else if (err_clr) begin
            stat_beats <= 16'd0;
        end else if (accept && (stat_beats != 16'hFFFF)) begin
            stat_beats <= stat_beats + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_gnt_mux.sv
// Testbench for rr_gnt_mux: table vectors, directed multi-cycle sequences and
// random traffic, all checked against a queue-based reference model.
module tb_rr_gnt_mux;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  gnt = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  req_last = 4'd0;
    logic [3:0]  ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        lock_act;
    logic [1:0]  lock_src;
    logic        err_clr = 1'b0;
    logic        gnt_err;
    logic        burst_err;
`ifdef RR_GNT_MUX_STATS_EN
    logic [15:0] stat_beats;
`endif

    rr_gnt_mux #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .req_data(req_data), .req_last(req_last),
        .ack(ack), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_last(out_last), .out_ready(out_ready), .lock_act(lock_act),
        .lock_src(lock_src), .err_clr(err_clr), .gnt_err(gnt_err), .burst_err(burst_err)
`ifdef RR_GNT_MUX_STATS_EN
        , .stat_beats(stat_beats)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0] src;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t m_q[$];
    bit    m_lock;
    int    m_src;
    int    m_beats;
    bit    m_gerr;
    bit    m_berr;
    int    m_stat;

    task automatic m_reset();
        m_q.delete();
        m_lock = 0; m_src = 0; m_beats = 0;
        m_gerr = 0; m_berr = 0; m_stat = 0;
    endtask

    function automatic int m_idx();
        for (int i = 0; i < 4; i++) if (gnt[i]) return i;
        return 0;
    endfunction

    function automatic bit m_accept();
        return ($countones(gnt) == 1) && (m_q.size() < 2) && (!m_lock || gnt[m_src]);
    endfunction

    task automatic check_model();
        chk("ack", 32'(ack), m_accept() ? 32'(gnt) : 32'd0);
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(m_q[0].data));
            chk("out_src", 32'(out_src), 32'(m_q[0].src));
            chk("out_last", 32'(out_last), 32'(m_q[0].last));
        end
        chk("lock_act", 32'(lock_act), 32'(m_lock));
        if (m_lock) chk("lock_src", 32'(lock_src), 32'(m_src));
        chk("gnt_err", 32'(gnt_err), 32'(m_gerr));
        chk("burst_err", 32'(burst_err), 32'(m_berr));
`ifdef RR_GNT_MUX_STATS_EN
        chk("stat_beats", 32'(stat_beats), 32'(m_stat));
`endif
    endtask

    task automatic m_step();
        bit    acc, popq, bnew;
        int    i;
        beat_t b;
        acc  = m_accept();
        popq = (m_q.size() > 0) && out_ready;
        bnew = 0;
        i    = m_idx();
        if (acc) begin
            b.src  = 2'(i);
            b.last = req_last[i];
            b.data = req_data[i*8 +: 8];
            if (!m_lock) begin
                if (!b.last) begin m_lock = 1; m_src = i; m_beats = 1; end
            end else if (b.last) begin
                m_lock = 0; m_beats = 0;
            end else begin
                m_beats++;
                if (m_beats == MAX_BURST) begin m_lock = 0; m_beats = 0; bnew = 1; end
            end
        end
        m_gerr = ($countones(gnt) > 1) || (m_gerr && !err_clr);
        m_berr = bnew || (m_berr && !err_clr);
        if (err_clr) m_stat = 0;
        else if (acc && m_stat < 16'hFFFF) m_stat++;
        if (popq) void'(m_q.pop_front());
        if (acc) m_q.push_back(b);
    endtask

    // Drive inputs one step after an edge, settle, compare against the model.
    task automatic apply(input logic [3:0] g, input logic [3:0] l, input logic [31:0] d,
                         input logic r, input logic c);
        gnt = g; req_last = l; req_data = d; out_ready = r; err_clr = c;
        #1;
        check_model();
    endtask

    task automatic advance();
        m_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0]  gnt;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ready;
        logic        clr;
        logic [3:0]  exp_ack;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_src;
        logic        exp_last;
        logic        exp_lock;
        logic        exp_gerr;
        logic        exp_berr;
    } vec_t;

    vec_t vecs[9];

    logic [7:0] got[$];
    logic [7:0] want3[3];

    initial begin
        // single-beat packet, then bad grant and sticky clear behaviour
        vecs[0] = '{4'b0010, 4'b0010, 32'h0000_A500, 1'b1, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'b0101, 4'b0000, 32'h1122_3344, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'b0011, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        want3[0] = 8'h11; want3[1] = 8'h22; want3[2] = 8'h33;

        // ---- clock/reset ----
        m_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_lock_act", 32'(lock_act), 32'd0);
        chk("rst_lock_src", 32'(lock_src), 32'd0);
        chk("rst_gnt_err", 32'(gnt_err), 32'd0);
        chk("rst_burst_err", 32'(burst_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- table ----
        for (int v = 0; v < 9; v++) begin
            apply(vecs[v].gnt, vecs[v].last, vecs[v].data, vecs[v].ready, vecs[v].clr);
            chk($sformatf("vec%0d_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].exp_data));
                chk($sformatf("vec%0d_src", v), 32'(out_src), 32'(vecs[v].exp_src));
                chk($sformatf("vec%0d_last", v), 32'(out_last), 32'(vecs[v].exp_last));
            end
            chk($sformatf("vec%0d_lock", v), 32'(lock_act), 32'(vecs[v].exp_lock));
            chk($sformatf("vec%0d_gerr", v), 32'(gnt_err), 32'(vecs[v].exp_gerr));
            chk($sformatf("vec%0d_berr", v), 32'(burst_err), 32'(vecs[v].exp_berr));
            advance();
        end

        // ---- 3-beat packet from requester 2, grants alternating with requester 3 ----
        got.delete();
        for (int c = 0; c < 10; c++) begin
            logic [3:0]  g;
            logic [3:0]  l;
            logic [31:0] d;
            g = 4'b0000; l = 4'b1000; d = 32'h4400_0000;
            if (c < 6) g = (c % 2 == 0) ? 4'b0100 : 4'b1000;
            if (c < 6 && c % 2 == 0) begin
                d[23:16] = want3[c / 2];
                l[2]     = (c == 4);
            end
            apply(g, l, d, 1'b1, 1'b0);
            if (c < 5) chk($sformatf("pkt3_ack%0d", c), 32'(ack), (c % 2 == 0) ? 32'h4 : 32'h0);
            if (c == 5) begin
                chk("pkt3_unlocked", 32'(lock_act), 32'd0);
                chk("pkt3_req3_acked", 32'(ack), 32'h8);
            end
            if (out_valid && out_src == 2'd2) got.push_back(out_data);
            advance();
        end
        chk("pkt3_count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < got.size()) chk($sformatf("pkt3_order%0d", k), 32'(got[k]), 32'(want3[k]));

        // ---- backpressure from requester 0 ----
        begin
            logic [3:0] exp_ack[6];
            logic [7:0] exp_hd[6];
            logic       rdy[6];
            int         nxt;
            exp_ack = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
            exp_hd  = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03};
            rdy     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            nxt = 1;
            for (int c = 0; c < 6; c++) begin
                apply((nxt <= 3) ? 4'b0001 : 4'b0000, 4'b0001, 32'(nxt), rdy[c], 1'b0);
                chk($sformatf("bp_ack%0d", c), 32'(ack), 32'(exp_ack[c]));
                if (c > 0) chk($sformatf("bp_head%0d", c), 32'(out_data), 32'(exp_hd[c]));
                if (ack[0]) nxt++;
                advance();
            end
        end
        apply(4'b0000, 4'b0000, 32'd0, 1'b1, 1'b0);
        advance();

        // ---- burst overflow from requester 3 ----
        for (int c = 0; c < MAX_BURST; c++) begin
            apply(4'b1000, 4'b0000, 32'(c + 1) << 24, 1'b1, 1'b0);
            chk($sformatf("burst_ack%0d", c), 32'(ack), 32'h8);
            advance();
        end
        apply(4'b0001, 4'b0001, 32'h0000_0077, 1'b1, 1'b0);
        chk("burst_err_set", 32'(burst_err), 32'd1);
        chk("burst_unlock", 32'(lock_act), 32'd0);
        chk("burst_next_ack", 32'(ack), 32'h1);
        advance();
        apply(4'b0000, 4'b0000, 32'd0, 1'b1, 1'b0);
        advance();

        // ---- reset while locked with two beats buffered ----
        for (int c = 0; c < 2; c++) begin
            apply(4'b0010, 4'b0000, 32'(c + 8'h50) << 8, 1'b0, 1'b0);
            advance();
        end
        chk("pre_rst_lock", 32'(lock_act), 32'd1);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        gnt = 4'b0000;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_lock", 32'(lock_act), 32'd0);
        chk("mid_rst_gerr", 32'(gnt_err), 32'd0);
        chk("mid_rst_berr", 32'(burst_err), 32'd0);
`ifdef RR_GNT_MUX_STATS_EN
        chk("mid_rst_stat", 32'(stat_beats), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        apply(4'b0000, 4'b0000, 32'd0, 1'b1, 1'b0);
        chk("post_rst_ack", 32'(ack), 32'd0);
        advance();

        // ---- random traffic against the model ----
        for (int c = 0; c < 600; c++) begin
            logic [3:0]  g;
            logic [3:0]  l;
            int          r;
            r = $urandom_range(0, 9);
            if (r <= 5)      g = 4'(1 << $urandom_range(0, 3));
            else if (r <= 7) g = 4'b0000;
            else             g = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) l[i] = ($urandom_range(0, 3) == 0);
            apply(g, l, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
